dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_if.sv | 34 +++
 rtl/dmem_responder.sv | 113 +++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// CPU-side data-memory bus between a load/store unit (master) and the
// responder (slave); clock and reset travel as plain ports.
interface dmem_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i,
    output we_i,
    output addr_i,
    output wdata_i,
    input  busy_o,
    input  ack_o,
    input  rdata_o,
    input  err_o
  );

  modport slave (
    input  req_i,
    input  we_i,
    input  addr_i,
    input  wdata_i,
    output busy_o,
    output ack_o,
    output rdata_o,
    output err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data memory responder: accepts one request, waits LATENCY
// cycles, performs the access and pulses ack for one cycle.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  dmem_if.slave  bus
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          busy_q;
  logic          ack_q;
  logic          err_q;
  logic [31:0]   rdata_q;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          fault_s;
  logic          access_s;
  logic [AW-1:0] word_idx_s;

  // Fault is judged only on the request as latched at acceptance.
  assign fault_s    = (addr_q[1:0] != 2'b00) || (addr_q >= ADDR_LIMIT);
  assign word_idx_s = addr_q[AW+1:2];
  assign access_s   = (state_q == S_WAIT) && (cnt_q == 4'd0);

  assign bus.busy_o  = busy_q;
  assign bus.ack_o   = ack_q;
  assign bus.err_o   = err_q;
  assign bus.rdata_o = rdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_i) begin
            we_q    <= bus.we_i;
            addr_q  <= bus.addr_i;
            wdata_q <= bus.wdata_i;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= S_WAIT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= S_DONE;
            ack_q   <= 1'b1;
            err_q   <= fault_s;
            // Stores leave rdata untouched; faulted loads return zero.
            if (!we_q) begin
              rdata_q <= fault_s ? 32'd0 : mem_q[word_idx_s];
            end else begin
              rdata_q <= rdata_q;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 4'd0;
          busy_q  <= 1'b0;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  // Storage survives reset; an async reset drops state_q to IDLE so an
  // aborted transaction never reaches the write.
  always_ff @(posedge clk_i) begin
    if (access_s && we_q && !fault_s) begin
      mem_q[word_idx_s] <= wdata_q;
    end
  end

endmodule
